// File: rtl/display_scanner.sv
// ---------------------------------------------------------------------------
// display_scanner
//   Time-multiplexed driver for a 4-digit, 7-segment hex display.
//   A prescaler divides each digit slot into DIV clock cycles. The first
//   BLANK_CYC cycles of every slot are forced dark, which suppresses ghosting
//   while the anode decoder switches. New display data is double-buffered.
//   A load request is captured into a pending buffer. That buffer is
//   committed only at the frame boundary (digit_sel wrapping 3->0), so the
//   digits never change in the middle of a frame.
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   rst_n       synchronous, active-low reset
//   value       four hex digits; digit d = value[4d+3:4d]
//   dp_mask     bit d lights the decimal point of digit d
//   blank_mask  bit d forces digit d dark
//   load        one-cycle capture request for value/dp_mask/blank_mask
//   load_ack    one-cycle pulse when pending data is committed
//   digit_sel   active digit index (feeds the external anode decoder)
//   seg_n       segments {g,f,e,d,c,b,a}, active-low
//   dp_n        decimal point, active-low
//   frame_tick  one-cycle pulse in the first cycle after digit_sel wraps 3->0
// ---------------------------------------------------------------------------
module display_scanner #(
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic [3:0]  dp_mask,
   input  logic [3:0]  blank_mask,
   input  logic        load,
   output logic        load_ack,
   output logic [1:0]  digit_sel,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic        frame_tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   // Active-low hex font, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex_font(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   logic [CW-1:0] cnt;
   logic          pend;
   logic [15:0]   pend_v;
   logic [3:0]    pend_dp;
   logic [3:0]    pend_bl;
   logic [15:0]   com_v;
   logic [3:0]    com_dp;
   logic [3:0]    com_bl;

   logic          slot_end;
   logic          commit;
   logic [CW-1:0] cnt_nx;
   logic [1:0]    sel_nx;
   logic [15:0]   com_v_nx;
   logic [3:0]    com_dp_nx;
   logic [3:0]    com_bl_nx;
   logic [3:0]    digit_nx;
   logic          dark_nx;
   logic [6:0]    seg_nx;
   logic          dp_nx;

   // The outputs are registered. They are therefore computed from the
   // *next* prescaler, digit and committed data. This keeps seg_n/dp_n
   // aligned with the digit_sel value that is shown in the same cycle.
   always_comb begin
      slot_end  = (cnt == LAST);
      commit    = slot_end && (digit_sel == 2'd3) && pend;
      cnt_nx    = slot_end ? '0 : cnt + CW'(1);
      sel_nx    = slot_end ? digit_sel + 2'd1 : digit_sel;
      com_v_nx  = commit ? pend_v  : com_v;
      com_dp_nx = commit ? pend_dp : com_dp;
      com_bl_nx = commit ? pend_bl : com_bl;
      digit_nx  = com_v_nx[{sel_nx, 2'b00} +: 4];
      dark_nx   = (int'(cnt_nx) < BLANK_CYC) || com_bl_nx[sel_nx];
      seg_nx    = dark_nx ? 7'h7F : hex_font(digit_nx);
      dp_nx     = dark_nx ? 1'b1  : ~com_dp_nx[sel_nx];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         digit_sel  <= 2'd0;
         pend       <= 1'b0;
         pend_v     <= 16'h0;
         pend_dp    <= 4'h0;
         pend_bl    <= 4'h0;
         com_v      <= 16'h0;
         com_dp     <= 4'h0;
         com_bl     <= 4'hF;
         seg_n      <= 7'h7F;
         dp_n       <= 1'b1;
         load_ack   <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         cnt        <= cnt_nx;
         digit_sel  <= sel_nx;
         com_v      <= com_v_nx;
         com_dp     <= com_dp_nx;
         com_bl     <= com_bl_nx;
         seg_n      <= seg_nx;
         dp_n       <= dp_nx;
         load_ack   <= commit;
         frame_tick <= slot_end && (digit_sel == 2'd3);
         // A load on the commit edge replaces the buffer that is being
         // committed in this same edge. The pending flag stays set in
         // that case.
         if (load) begin
            pend    <= 1'b1;
            pend_v  <= value;
            pend_dp <= dp_mask;
            pend_bl <= blank_mask;
         end else if (commit) begin
            pend    <= 1'b0;
         end
      end
   end

endmodule
